reload_down_counter: RTL and testbench

Loadable down-counter/timer: the counting-down complement of the team's 8-bit loadable up-counter, using the same `en`/`ld`/`data`/`Q` control style. It counts a loaded value down to terminal count, pulses `tc`, then stops (one-shot) or reloads itself (auto-reload). It serves as the period/timeout generator beside the up-counter in the lab designs.

---
 rtl/reload_down_counter.sv | 78 +++++++
 tb/tb_reload_down_counter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/reload_down_counter.sv
// reload_down_counter: loadable down-counter/timer.
// Counts a loaded value down to terminal count, pulses tc_o for one cycle,
// then either stops (one-shot) or reloads from the captured load value
// (auto-reload). All outputs are registered; reset is asynchronous.
module reload_down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             ld_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] q_o,
  output logic             tc_o,
  output logic             busy_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // State, count, reload value and tc pulse register; reset clears everything.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  // Next-state logic: load wins over everything, counting happens only in RUN.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (ld_i) begin
      // A load discards any terminal count that would have fired this edge.
      cnt_d    = data_i;
      reload_d = data_i;
      state_d  = (data_i != '0) ? RUN : IDLE;
    end else if (state_q == RUN && en_i) begin
      if (cnt_q > ONE) begin
        cnt_d = cnt_q - ONE;
      end else begin
        // In RUN the count is never zero, so this is the count==1 case.
        tc_d = 1'b1;
        if (mode_i) begin
          cnt_d = reload_q;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
    end
  end

  assign q_o    = cnt_q;
  assign tc_o   = tc_q;
  assign busy_o = (state_q == RUN);

endmodule

// File: tb/tb_reload_down_counter.sv
// Directed and random-stress bench for reload_down_counter.
module tb_reload_down_counter;

  localparam int WIDTH = 8;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             en_i = 1'b0;
  logic             ld_i = 1'b0;
  logic             mode_i = 1'b0;
  logic [WIDTH-1:0] data_i = '0;
  logic [WIDTH-1:0] q_o;
  logic             tc_o;
  logic             busy_o;

  int checks = 0;
  int errors = 0;
  bit verbose = 1'b1;

  // Reference model state.
  logic [WIDTH-1:0] m_q = '0;
  logic [WIDTH-1:0] m_r = '0;
  logic             m_run = 1'b0;
  logic             m_tc = 1'b0;

  reload_down_counter #(.WIDTH(WIDTH)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (en_i),
    .ld_i   (ld_i),
    .mode_i (mode_i),
    .data_i (data_i),
    .q_o    (q_o),
    .tc_o   (tc_o),
    .busy_o (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge: advance the reference model with the current inputs,
  // then compare all outputs shortly after the edge.
  task automatic step(input string tag);
    logic [WIDTH-1:0] nq, nr;
    logic             nrun, ntc;
    nq = m_q; nr = m_r; nrun = m_run; ntc = 1'b0;
    if (ld_i) begin
      nq = data_i; nr = data_i; nrun = (data_i != 0);
    end else if (m_run && en_i) begin
      if (m_q == 1) begin
        ntc = 1'b1;
        if (mode_i) nq = m_r;
        else begin nq = 0; nrun = 1'b0; end
      end else begin
        nq = m_q - 1'b1;
      end
    end
    @(posedge clk_i);
    m_q = nq; m_r = nr; m_run = nrun; m_tc = ntc;
    #1;
    check({tag, "_mq"}, 32'(q_o), 32'(m_q));
    check({tag, "_mtc"}, 32'(tc_o), 32'(m_tc));
    check({tag, "_mbusy"}, 32'(busy_o), 32'(m_run));
    if (verbose)
      $display("%s: ld=%0b en=%0b mode=%0b data=%0d -> q=%0d tc=%0b busy=%0b",
               tag, ld_i, en_i, mode_i, data_i, q_o, tc_o, busy_o);
  endtask

  // Hand-computed expectation for the state just observed.
  task automatic expect3(input string tag, input int q, input int tc, input int busy);
    check({tag, "_q"}, 32'(q_o), 32'(q));
    check({tag, "_tc"}, 32'(tc_o), 32'(tc));
    check({tag, "_busy"}, 32'(busy_o), 32'(busy));
  endtask

  initial begin
    #400000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    int qa[9];
    int en_pat[12];
    int q_pat[12];
    int tc_pat[12];

    // Power-on reset.
    rst_i = 1'b1;
    #12;
    expect3("por", 0, 0, 0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Reset mid-count.
    ld_i = 1'b1; data_i = 8'd200; en_i = 1'b1; mode_i = 1'b0;
    step("rst_ld");
    ld_i = 1'b0;
    for (int i = 0; i < 10; i++) step("rst_run");
    expect3("rst_pre", 190, 0, 1);
    #2 rst_i = 1'b1;
    #1;
    expect3("rst_async", 0, 0, 0);
    m_q = 0; m_r = 0; m_run = 1'b0; m_tc = 1'b0;
    #1 rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("rst_hold");
      expect3("rst_hold", 0, 0, 0);
    end

    // One-shot with data 3.
    mode_i = 1'b0; en_i = 1'b1; ld_i = 1'b1; data_i = 8'd3;
    step("os_ld");  expect3("os0", 3, 0, 1);
    ld_i = 1'b0;
    step("os");     expect3("os1", 2, 0, 1);
    step("os");     expect3("os2", 1, 0, 1);
    step("os");     expect3("os3", 0, 1, 0);
    step("os");     expect3("os4", 0, 0, 0);
    step("os");     expect3("os5", 0, 0, 0);

    // Auto-reload with data 4.
    qa = '{4, 3, 2, 1, 4, 3, 2, 1, 4};
    mode_i = 1'b1; ld_i = 1'b1; data_i = 8'd4;
    step("ar_ld");
    ld_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step("ar");
      expect3("ar", qa[i], (i == 4 || i == 8) ? 1 : 0, 1);
    end

    // Auto-reload with data 1: tc every enabled edge.
    ld_i = 1'b1; data_i = 8'd1;
    step("ar1_ld"); expect3("ar1_ld", 1, 0, 1);
    ld_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step("ar1");
      expect3("ar1", 1, 1, 1);
    end

    // Enable gating, load 5, en toggling every two edges.
    en_pat = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1};
    q_pat  = '{5, 5, 4, 3, 3, 3, 2, 1, 1, 1, 0, 0};
    tc_pat = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    mode_i = 1'b0; en_i = 1'b0; ld_i = 1'b1; data_i = 8'd5;
    step("eg_ld"); expect3("eg_ld", 5, 0, 1);
    ld_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      en_i = en_pat[i][0];
      step("eg");
      expect3("eg", q_pat[i], tc_pat[i], (i < 10) ? 1 : 0);
    end

    // Load priority over a pending terminal count.
    en_i = 1'b1; ld_i = 1'b1; data_i = 8'd2;
    step("lp_ld");
    ld_i = 1'b0;
    step("lp");    expect3("lp_at1", 1, 0, 1);
    ld_i = 1'b1; data_i = 8'd7;
    step("lp_ld7"); expect3("lp_ld7", 7, 0, 1);
    ld_i = 1'b0;
    step("lp");    expect3("lp_after", 6, 0, 1);

    // Zero load.
    ld_i = 1'b1; data_i = 8'd0;
    step("zl");    expect3("zl", 0, 0, 0);
    ld_i = 1'b0;
    step("zl");    expect3("zl_hold", 0, 0, 0);

    // Random stress against the reference model.
    verbose = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      ld_i   = ($urandom_range(0, 7) == 0);
      en_i   = ($urandom_range(0, 3) != 0);
      mode_i = $urandom_range(0, 1) != 0;
      data_i = ($urandom_range(0, 9) == 0) ? 8'(($urandom_range(0, 255)))
                                           : 8'(($urandom_range(0, 6)));
      step("rnd");
    end
    $display("random stress: 2000 cycles compared");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
